lsu_mem_port: RTL and testbench
===============================

Name: lsu_mem_port

Overview:
- Load/store unit on the processor side of the single-port memory bus (mem_addr / mem_rdata / mem_rstrb / mem_wdata / mem_wmask).
- Accepts one load or store per request from the core's execute stage and computes the effective address.
- Generates byte-lane write masks and replicated write data, issues the read strobe, and waits the fixed memory read latency.
- Aligns and sign- or zero-extends load data, flags misaligned or illegal accesses, and returns completion with a one-cycle done pulse.

Parameters:
- RDATA_LATENCY, 1: clock edges from the mem_rstrb cycle until mem_rdata is valid. Legal range 1..4.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  1  start operation; sampled only when busy=0.
- is_store  in  1  1 = store, 0 = load; sampled with req.
- funct3  in  3  RV32I width code; sampled with req.
- base  in  32  rs1 value; sampled with req.
- offset  in  32  sign-extended immediate; sampled with req.
- store_data  in  32  rs2 value; sampled with req.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle pulse on completion (success or error).
- err  out  1  valid with done; 1 = misaligned or illegal funct3.
- load_data  out  32  extended load result; valid with done on a successful load; held until the next load completes.
- mem_addr  out  32  byte address to memory.
- mem_rstrb  out  1  read strobe.
- mem_rdata  in  32  read data from memory.
- mem_wdata  out  32  write data.
- mem_wmask  out  4  byte write enables.

Behaviour:
- Reset (async, resetn=0): state IDLE; busy, done, err, mem_rstrb, mem_wmask, mem_addr, mem_wdata and load_data all 0, taking effect immediately. A pending write is aborted; no mask leaks.
- Effective address: ea = base + offset, mod 2^32, latched when req is accepted.
- States: IDLE, LD_REQ, LD_WAIT, ST_REQ, FIN.
- IDLE (req=1, busy=0, cycle 0): latch ea, funct3 and store_data.
  - Illegal/misaligned → FIN with err=1.
  - Otherwise load → LD_REQ; store → ST_REQ.
- Load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Others illegal.
- Store funct3: 000 SB, 001 SH, 010 SW. Others illegal.
- Misaligned: halfword with ea[0]=1; word with ea[1:0]≠0.
- LD_REQ (cycle 1):
  - mem_addr=ea, mem_rstrb=1 for exactly this cycle.
  - Go to LD_WAIT and load a counter with RDATA_LATENCY-1.
- LD_WAIT:
  - mem_rstrb=0; count down.
  - At count 0, capture mem_rdata, extract, register load_data and go to FIN.
  - With RDATA_LATENCY=1, LD_WAIT lasts one cycle (cycle 2).
- Load extraction by ea[1:0]:
  - Byte: lane ea[1:0].
  - Halfword: ea[1] ? [31:16] : [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word unchanged.
- ST_REQ (cycle 1): mem_addr=ea for exactly one cycle; go to FIN.
  - SB: mem_wmask = 4'b0001 << ea[1:0]; mem_wdata = byte replicated ×4.
  - SH: mem_wmask = ea[1] ? 1100 : 0011; mem_wdata = halfword replicated ×2.
  - SW: mem_wmask = 1111; mem_wdata = store_data.
- FIN: done=1 (err as determined) for one cycle; mem_wmask=0, mem_rstrb=0; busy=0 in FIN; return to IDLE.
- A req in FIN is accepted exactly as in IDLE, which gives back-to-back operation.
- Latency from req cycle to done:
  - Load: 2+RDATA_LATENCY cycles (3 at default).
  - Store: 2 cycles.
  - Error: 1 cycle, with no mem_rstrb and no mem_wmask ever asserted.
- busy=1 in LD_REQ, LD_WAIT and ST_REQ. A req while busy is ignored, not queued.
- mem_rstrb and mem_wmask≠0 are never asserted in the same cycle.
- mem_addr holds its last value outside active cycles. load_data is unchanged by stores and errors.

Test Plan:
- Memory word at byte address 412 = 0xff0f0e0d. LB base=400, off=15 → mem_rstrb in cycle 1 with mem_addr=415; done in cycle 3; load_data=0xffffffff, err=0. LBU same address → 0x000000ff.
- LH ea=414 → 0xffffff0f. LHU ea=414 → 0x0000ff0f. LW ea=412 → 0xff0f0e0d.
- SB ea=801, store_data=0x1234565a → cycle 1: mem_wmask=0010, mem_wdata=0x5a5a5a5a; done in cycle 2. A following LBU from 801 returns 0x0000005a.
- SH ea=802, store_data=0xbeef → mem_wmask=1100, mem_wdata=0xbeefbeef. LW ea=402 → done+err in cycle 1, no strobe or mask. funct3=011 load → err.
- Back-to-back: new req in the FIN cycle is accepted. A req during LD_WAIT is ignored: exactly one done, load_data unchanged.
- Drop resetn during LD_WAIT or in the ST_REQ cycle → all outputs 0 immediately, no done pulse; after release, an LW ea=400 returns 0x04030201.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit driving a single-port memory bus: effective address, byte-lane
// store masks, fixed-latency loads with sign/zero extension, and a one-cycle done.
module lsu_mem_port #(
  parameter int RDATA_LATENCY = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] base,
  input  logic [31:0] offset,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask
);

  typedef enum logic [2:0] {IDLE, LD_REQ, LD_WAIT, ST_REQ, FIN} state_t;

  localparam logic [1:0] CNT_INIT = 2'(RDATA_LATENCY - 1);

  state_t      state_reg, state_next;
  logic [1:0]  ea_lo_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  cnt_reg;
  logic        err_reg;
  logic [31:0] load_data_reg;
  logic [31:0] mem_addr_reg;
  logic [31:0] mem_wdata_reg;
  logic [3:0]  mem_wmask_reg;
  logic        mem_rstrb_reg;

  logic [31:0] ea_next;
  logic        accept;
  logic        req_bad;

  function automatic logic access_bad(input logic st, input logic [2:0] f3, input logic [1:0] a);
    logic legal;
    logic misal;
    legal = st ? (!f3[2] && f3[1:0] != 2'b11)
               : (f3[1:0] != 2'b11 && !(f3[2] && f3[1]));
    misal = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
    return !legal || misal;
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(w >> {a, 3'b000});
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'b0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'b0, h};
      default: return w;
    endcase
  endfunction

  assign ea_next = base + offset;
  // FIN behaves like IDLE for acceptance so operations can run back-to-back
  assign accept  = req && (state_reg == IDLE || state_reg == FIN);
  assign req_bad = access_bad(is_store, funct3, ea_next[1:0]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, FIN: begin
        if (!accept)      state_next = IDLE;
        else if (req_bad) state_next = FIN;
        else if (is_store) state_next = ST_REQ;
        else              state_next = LD_REQ;
      end
      LD_REQ:  state_next = LD_WAIT;
      LD_WAIT: if (cnt_reg == 2'd0) state_next = FIN;
      ST_REQ:  state_next = FIN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ea_lo_reg     <= 2'b0;
      funct3_reg    <= 3'b0;
      cnt_reg       <= 2'b0;
      err_reg       <= 1'b0;
      load_data_reg <= 32'b0;
      mem_addr_reg  <= 32'b0;
      mem_wdata_reg <= 32'b0;
      mem_wmask_reg <= 4'b0;
      mem_rstrb_reg <= 1'b0;
    end else begin
      // strobe and mask are single-cycle; they only rise on acceptance below
      mem_rstrb_reg <= 1'b0;
      mem_wmask_reg <= 4'b0;
      if (accept) begin
        ea_lo_reg  <= ea_next[1:0];
        funct3_reg <= funct3;
        err_reg    <= req_bad;
        if (!req_bad) begin
          mem_addr_reg <= ea_next;
          if (is_store) begin
            case (funct3[1:0])
              2'b00: begin
                mem_wmask_reg <= 4'b0001 << ea_next[1:0];
                mem_wdata_reg <= {4{store_data[7:0]}};
              end
              2'b01: begin
                mem_wmask_reg <= ea_next[1] ? 4'b1100 : 4'b0011;
                mem_wdata_reg <= {2{store_data[15:0]}};
              end
              default: begin
                mem_wmask_reg <= 4'b1111;
                mem_wdata_reg <= store_data;
              end
            endcase
          end else begin
            mem_rstrb_reg <= 1'b1;
          end
        end
      end
      if (state_reg == LD_REQ) begin
        cnt_reg <= CNT_INIT;
      end else if (state_reg == LD_WAIT) begin
        if (cnt_reg == 2'd0) load_data_reg <= load_extract(funct3_reg, ea_lo_reg, mem_rdata);
        else                 cnt_reg <= cnt_reg - 2'd1;
      end
    end
  end

  assign busy      = (state_reg == LD_REQ) || (state_reg == LD_WAIT) || (state_reg == ST_REQ);
  assign done      = (state_reg == FIN);
  assign err       = (state_reg == FIN) && err_reg;
  assign load_data = load_data_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_rstrb = mem_rstrb_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_wmask = mem_wmask_reg;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized and directed bench for lsu_mem_port against a byte-addressed
// reference memory and access rules computed directly from the ISA widths.
module tb_lsu_mem_port;
  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] base = 32'b0;
  logic [31:0] offset = 32'b0;
  logic [31:0] store_data = 32'b0;
  logic        busy, done, err, mem_rstrb;
  logic [31:0] load_data, mem_addr, mem_rdata, mem_wdata;
  logic [3:0]  mem_wmask;

  lsu_mem_port #(.RDATA_LATENCY(LAT)) dut (
    .clk(clk), .resetn(resetn), .req(req), .is_store(is_store), .funct3(funct3),
    .base(base), .offset(offset), .store_data(store_data), .busy(busy), .done(done),
    .err(err), .load_data(load_data), .mem_addr(mem_addr), .mem_rstrb(mem_rstrb),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask)
  );

  always #5 clk = ~clk;

  // bus-side memory with fixed read latency; idle read data is random garbage
  logic [7:0]  bus_mem [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic [31:0] rd_pipe [LAT];

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    return {bus_mem[{a[9:2], 2'd3}], bus_mem[{a[9:2], 2'd2}],
            bus_mem[{a[9:2], 2'd1}], bus_mem[{a[9:2], 2'd0}]};
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < 4; l++)
      if (mem_wmask[l]) bus_mem[{mem_addr[9:2], 2'(l)}] <= mem_wdata[8*l +: 8];
    rd_pipe[0] <= mem_rstrb ? rd_word(mem_addr) : $urandom;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // next operation for chaining (in FIN) or injection (while busy)
  logic        nx_st;
  logic [2:0]  nx_f3;
  logic [31:0] nx_base, nx_off, nx_sd;
  // observations of one operation
  int          o_done_cyc, o_rs_cnt, o_rs_cyc, o_wm_cnt, o_wm_cyc;
  logic        o_err, o_ovl;
  logic [31:0] o_ld, o_rs_addr, o_wa, o_wd;
  logic [3:0]  o_wm;
  logic [31:0] last_ld = 32'b0;

  task automatic go(input logic st, input logic [2:0] f3, input logic [31:0] b,
                    input logic [31:0] o, input logic [31:0] sd);
    is_store = st; funct3 = f3; base = b; offset = o; store_data = sd; req = 1'b1;
  endtask

  task automatic drive_nx();
    go(nx_st, nx_f3, nx_base, nx_off, nx_sd);
  endtask

  task automatic set_nx(input logic st, input logic [2:0] f3, input logic [31:0] b,
                        input logic [31:0] o, input logic [31:0] sd);
    nx_st = st; nx_f3 = f3; nx_base = b; nx_off = o; nx_sd = sd;
  endtask

  // Called at posedge+1 of the req cycle (or of cycle 1 when pre is set).
  task automatic wait_op(input int inject, input bit chain, input bit pre);
    int n;
    o_done_cyc = -1; o_err = 0; o_ld = 0; o_ovl = 0;
    o_rs_cnt = 0; o_rs_cyc = 0; o_rs_addr = 0; o_wm_cnt = 0; o_wm_cyc = 0;
    o_wa = 0; o_wd = 0; o_wm = 0;
    if (!pre) begin
      @(posedge clk);
      #1;
    end
    req = 1'b0;
    n = 1;
    while (o_done_cyc < 0 && n <= 20) begin
      if (inject > 0 && n == inject) drive_nx();
      else if (inject > 0 && n == inject + 1) req = 1'b0;
      @(negedge clk);
      if (mem_rstrb) begin o_rs_cnt++; o_rs_cyc = n; o_rs_addr = mem_addr; end
      if (mem_wmask != 4'b0) begin
        o_wm_cnt++; o_wm_cyc = n; o_wm = mem_wmask; o_wd = mem_wdata; o_wa = mem_addr;
      end
      if (mem_rstrb && mem_wmask != 4'b0) o_ovl = 1'b1;
      if (done) begin
        o_done_cyc = n; o_err = err; o_ld = load_data;
        if (chain) drive_nx();
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic exec_check(input string tag, input int inject, input bit chain, input bit pre);
    logic        st;
    logic [2:0]  f3;
    logic [31:0] ea, sd, exp_ld, exp_wd;
    logic [3:0]  exp_wm;
    int          size, a, lat;
    bit          bad;
    st = is_store; f3 = funct3; ea = base + offset; sd = store_data;
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    a = int'(ea[1:0]);
    bad = st ? !(f3 inside {3'd0, 3'd1, 3'd2}) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!bad && (a % size) != 0) bad = 1;
    exp_ld = 32'b0;
    for (int k = 0; k < size; k++) exp_ld |= 32'(ref_mem[10'(ea + 32'(k))]) << (8*k);
    if (!f3[2] && size < 4 && exp_ld[8*size-1]) exp_ld |= 32'hffffffff << (8*size);
    exp_wm = 4'b0;
    exp_wd = 32'b0;
    for (int k = 0; k < size; k++) exp_wm[(a+k)%4] = 1'b1;
    for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = sd[8*((i+4-a)%size) +: 8];
    lat = bad ? 1 : st ? 2 : 2 + LAT;

    wait_op(inject, chain, pre);

    chk({tag, " latency"}, 32'(o_done_cyc), 32'(lat));
    chk({tag, " err"}, 32'(o_err), 32'(bad));
    chk({tag, " strobe+mask overlap"}, 32'(o_ovl), 32'd0);
    if (bad) begin
      chk({tag, " bus activity"}, 32'(o_rs_cnt + o_wm_cnt), 32'd0);
      chk({tag, " load_data held"}, o_ld, last_ld);
    end else if (!st) begin
      chk({tag, " strobes"}, 32'(o_rs_cnt), 32'd1);
      chk({tag, " strobe cycle"}, 32'(o_rs_cyc), 32'd1);
      chk({tag, " strobe addr"}, o_rs_addr, ea);
      chk({tag, " masks"}, 32'(o_wm_cnt), 32'd0);
      chk({tag, " load_data"}, o_ld, exp_ld);
      last_ld = exp_ld;
    end else begin
      chk({tag, " masks"}, 32'(o_wm_cnt), 32'd1);
      chk({tag, " mask cycle"}, 32'(o_wm_cyc), 32'd1);
      chk({tag, " store addr"}, o_wa, ea);
      chk({tag, " wmask"}, 32'(o_wm), 32'(exp_wm));
      chk({tag, " wdata"}, o_wd, exp_wd);
      chk({tag, " strobes"}, 32'(o_rs_cnt), 32'd0);
      chk({tag, " load_data held"}, o_ld, last_ld);
      for (int k = 0; k < size; k++) ref_mem[10'(ea + 32'(k))] = sd[8*k +: 8];
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, " ctl"}, {24'b0, busy, done, err, mem_rstrb, mem_wmask}, 32'd0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, " load_data"}, load_data, 32'd0);
  endtask

  task automatic reset_hold_release(input string tag);
    int dn;
    dn = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk({tag, " done while reset"}, 32'(dn), 32'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int extra;
    bit pre;
    bit ch;
    for (int i = 0; i < 1024; i++) begin
      bus_mem[i] = 8'($urandom);
      ref_mem[i] = bus_mem[i];
    end
    for (int i = 0; i < 4; i++) begin
      bus_mem[400+i] = 8'(i + 1);
      ref_mem[400+i] = 8'(i + 1);
    end
    bus_mem[412] = 8'h0d; bus_mem[413] = 8'h0e; bus_mem[414] = 8'h0f; bus_mem[415] = 8'hff;
    ref_mem[412] = 8'h0d; ref_mem[413] = 8'h0e; ref_mem[414] = 8'h0f; ref_mem[415] = 8'hff;

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outs("reset");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    go(0, 3'b000, 32'd400, 32'd15, 32'd0); exec_check("LB 415", 0, 0, 0);
    chk("LB 415 value", o_ld, 32'hffffffff);
    go(0, 3'b100, 32'd400, 32'd15, 32'd0); exec_check("LBU 415", 0, 0, 0);
    chk("LBU 415 value", o_ld, 32'h000000ff);
    go(0, 3'b001, 32'd400, 32'd14, 32'd0); exec_check("LH 414", 0, 0, 0);
    chk("LH 414 value", o_ld, 32'hffffff0f);
    go(0, 3'b101, 32'd400, 32'd14, 32'd0); exec_check("LHU 414", 0, 0, 0);
    chk("LHU 414 value", o_ld, 32'h0000ff0f);
    go(0, 3'b010, 32'd412, 32'd0, 32'd0); exec_check("LW 412", 0, 0, 0);
    chk("LW 412 value", o_ld, 32'hff0f0e0d);
    go(1, 3'b000, 32'd800, 32'd1, 32'h1234565a); exec_check("SB 801", 0, 0, 0);
    chk("SB 801 wmask", 32'(o_wm), 32'h2);
    chk("SB 801 wdata", o_wd, 32'h5a5a5a5a);
    go(0, 3'b100, 32'd801, 32'd0, 32'd0); exec_check("LBU 801", 0, 0, 0);
    chk("LBU 801 value", o_ld, 32'h0000005a);
    go(1, 3'b001, 32'd800, 32'd2, 32'h0000beef); exec_check("SH 802", 0, 0, 0);
    chk("SH 802 wmask", 32'(o_wm), 32'hc);
    chk("SH 802 wdata", o_wd, 32'hbeefbeef);
    go(0, 3'b010, 32'd400, 32'd2, 32'd0); exec_check("LW 402 misaligned", 0, 0, 0);
    go(0, 3'b011, 32'd400, 32'd0, 32'd0); exec_check("load f3=011", 0, 0, 0);
    go(1, 3'b100, 32'd400, 32'd0, 32'd7); exec_check("store f3=100", 0, 0, 0);

    go(0, 3'b010, 32'd412, 32'd0, 32'd0);
    set_nx(0, 3'b100, 32'd801, 32'd0, 32'd0);
    exec_check("b2b first", 0, 1, 0);
    exec_check("b2b second", 0, 0, 1);
    chk("b2b second value", o_ld, 32'h0000005a);

    go(0, 3'b010, 32'd400, 32'd0, 32'd0);
    set_nx(1, 3'b010, 32'd400, 32'd0, 32'hdeadbeef);
    exec_check("req while busy", 2, 0, 0);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || mem_wmask != 4'b0) extra++;
    end
    @(posedge clk);
    #1;
    chk("busy req ignored", 32'(extra), 32'd0);
    go(0, 3'b010, 32'd400, 32'd0, 32'd0); exec_check("LW 400 after ignore", 0, 0, 0);
    chk("LW 400 after ignore value", o_ld, 32'h04030201);

    go(0, 3'b010, 32'd412, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    chk("busy in LD_WAIT", 32'(busy), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk_reset_outs("reset in LD_WAIT");
    last_ld = 32'b0;
    reset_hold_release("reset in LD_WAIT");
    go(0, 3'b010, 32'd400, 32'd0, 32'd0); exec_check("LW 400 after reset", 0, 0, 0);
    chk("LW 400 after reset value", o_ld, 32'h04030201);

    go(1, 3'b010, 32'd412, 32'd0, 32'ha5a5a5a5);
    @(posedge clk);
    #1;
    req = 1'b0;
    chk("ST_REQ wmask before reset", 32'(mem_wmask), 32'hf);
    #1;
    resetn = 1'b0;
    #1;
    chk_reset_outs("reset in ST_REQ");
    reset_hold_release("reset in ST_REQ");
    go(0, 3'b010, 32'd412, 32'd0, 32'd0); exec_check("LW 412 after aborted store", 0, 0, 0);
    chk("LW 412 after aborted store value", o_ld, 32'hff0f0e0d);

    pre = 0;
    for (int i = 0; i < 200; i++) begin
      if (!pre)
        go(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
           32'($urandom_range(0, 63)) - 32'd32, $urandom);
      ch = (i < 199) && ($urandom_range(0, 2) == 0);
      if (ch)
        set_nx(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
               32'($urandom_range(0, 63)) - 32'd32, $urandom);
      exec_check("random", 0, ch, pre);
      pre = ch;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
